// File: rtl/div_reconstruct_pkg.sv
// div_reconstruct_pkg
//   Handshake state encoding and counter sizing shared by the divider and
//   the dividend reconstructor, so both blocks walk identical IDLE/CALC/FINISH
//   sequences and can be probed with the same checkers.
package div_reconstruct_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t CALC   = 2'd1;
  localparam state_t FINISH = 2'd2;

  // Iteration counter width: must hold the values 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_reconstruct.sv
// div_reconstruct
//   Sequential shift-add multiply-accumulate that rebuilds
//   dividend = quotient * divisor + remainder from divider outputs and flags
//   results that cannot have come from a legal n-bit division.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   start      request pulse, sampled only in IDLE
//   quotient   multiplier operand (n bits)
//   divisor    multiplicand operand (n bits)
//   remainder  addend operand (n bits)
//   dividend   registered 2n-bit result
//   ovf        upper half of dividend non-zero
//   rem_err    remainder >= divisor (includes divisor == 0)
//   busy       high in CALC and FINISH
//   done       one-cycle pulse when results update
//   state_dbg  current FSM state, for observation only
//
// Handshake: start is accepted on an edge where the FSM is in IDLE; the
// operands are captured on that same edge and may change afterwards. done
// rises n+1 edges later for exactly one cycle; dividend/ovf/rem_err hold
// their values until the next completed operation. A start seen while busy
// is ignored.
module div_reconstruct
  import div_reconstruct_pkg::*;
#(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [n-1:0]   quotient,
  input  logic [n-1:0]   divisor,
  input  logic [n-1:0]   remainder,
  output logic [2*n-1:0] dividend,
  output logic           ovf,
  output logic           rem_err,
  output logic           busy,
  output logic           done,
  output logic [1:0]     state_dbg
);

  localparam int CW = cnt_width(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  state_t          state;
  state_t          state_nx;

  logic [2*n-1:0]  acc;
  logic [2*n-1:0]  mcand;
  logic [n-1:0]    mplier;
  logic [CW-1:0]   cnt;
  logic [n-1:0]    rem_l;
  logic [n-1:0]    div_l;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: fixed n iterations, no early exit on quotient == 0.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == LAST) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state == CALC) || (state == FINISH);
    state_dbg = state;
  end

  // Datapath. acc is 2n bits wide, enough for (2^n-1)^2 + (2^n-1), so the
  // add never carries out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      rem_l    <= '0;
      div_l    <= '0;
      dividend <= '0;
      ovf      <= 1'b0;
      rem_err  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= {{n{1'b0}}, remainder};
            mcand  <= {{n{1'b0}}, divisor};
            mplier <= quotient;
            cnt    <= '0;
            rem_l  <= remainder;
            div_l  <= divisor;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        FINISH: begin
          dividend <= acc;
          ovf      <= |acc[2*n-1:n];
          rem_err  <= (rem_l >= div_l);
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
